// File: rtl/freq_analysis_if.sv
// FFT frame input and peak-result output bundle for freq_analysis.
// master = FFT/consumer side, slave = the analysis block.
interface freq_analysis_if;
    logic        fft_valid;
    logic [31:0] fft_d0;
    logic [31:0] fft_d1;
    logic [31:0] fft_d2;
    logic [31:0] fft_d3;
    logic [31:0] fft_d4;
    logic [31:0] fft_d5;
    logic [31:0] fft_d6;
    logic [31:0] fft_d7;
    logic [31:0] fft_d8;
    logic [31:0] fft_d9;
    logic [31:0] fft_d10;
    logic [31:0] fft_d11;
    logic [31:0] fft_d12;
    logic [31:0] fft_d13;
    logic [31:0] fft_d14;
    logic [31:0] fft_d15;
    logic        done;
    logic [3:0]  freq;
    logic [31:0] max_mag;
    logic        busy;
    logic        ovf;

    modport master (
        output fft_valid,
        output fft_d0, fft_d1, fft_d2, fft_d3, fft_d4, fft_d5, fft_d6, fft_d7,
        output fft_d8, fft_d9, fft_d10, fft_d11, fft_d12, fft_d13, fft_d14, fft_d15,
        input  done, freq, max_mag, busy, ovf
    );

    modport slave (
        input  fft_valid,
        input  fft_d0, fft_d1, fft_d2, fft_d3, fft_d4, fft_d5, fft_d6, fft_d7,
        input  fft_d8, fft_d9, fft_d10, fft_d11, fft_d12, fft_d13, fft_d14, fft_d15,
        output done, freq, max_mag, busy, ovf
    );
endinterface

// File: rtl/freq_analysis.sv
// Peak-magnitude bin finder over 16-bin FFT frames, one bin per cycle,
// with a one-deep pending frame buffer and a sticky overflow flag.
module freq_analysis (
    input logic           clk,
    input logic           rst,
    freq_analysis_if.slave bus
);
    localparam int unsigned NBINS = 16;
    localparam int unsigned DW    = 32;
    localparam int unsigned HW    = 16;
    localparam int unsigned IW    = 4;

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

    state_t          state;
    logic [IW-1:0]   idx;
    logic            pend_vld;
    logic [DW-1:0]   work [NBINS];
    logic [DW-1:0]   pend [NBINS];
    logic [DW-1:0]   fft_d [NBINS];
    logic [DW-1:0]   best_mag;
    logic [IW-1:0]   best_idx;
    logic            done_q;
    logic            busy_q;
    logic            ovf_q;
    logic [IW-1:0]   freq_q;
    logic [DW-1:0]   max_mag_q;

    logic            last_c;
    logic            load_new_c;
    logic            load_pend_work_c;
    logic            cap_pend_c;
    logic            drop_c;
    logic signed [HW-1:0] re_c;
    logic signed [HW-1:0] im_c;
    logic [DW-1:0]   mag_c;
    logic            better_c;

    always_comb begin
        fft_d[0]  = bus.fft_d0;
        fft_d[1]  = bus.fft_d1;
        fft_d[2]  = bus.fft_d2;
        fft_d[3]  = bus.fft_d3;
        fft_d[4]  = bus.fft_d4;
        fft_d[5]  = bus.fft_d5;
        fft_d[6]  = bus.fft_d6;
        fft_d[7]  = bus.fft_d7;
        fft_d[8]  = bus.fft_d8;
        fft_d[9]  = bus.fft_d9;
        fft_d[10] = bus.fft_d10;
        fft_d[11] = bus.fft_d11;
        fft_d[12] = bus.fft_d12;
        fft_d[13] = bus.fft_d13;
        fft_d[14] = bus.fft_d14;
        fft_d[15] = bus.fft_d15;
    end

    // Frame routing: direct load, pending promotion, pending capture, or drop
    always_comb begin
        last_c           = (state == CALC) && (idx == IW'(NBINS - 1));
        load_new_c       = bus.fft_valid && ((state == IDLE) || (last_c && !pend_vld));
        load_pend_work_c = last_c && pend_vld;
        cap_pend_c       = bus.fft_valid && (state == CALC) &&
                           ((last_c && pend_vld) || (!last_c && !pend_vld));
        drop_c           = bus.fft_valid && (state == CALC) && !last_c && pend_vld;
    end

    // Squares of signed halves; the only overflow case (-32768,-32768) lands on 0x8000_0000
    always_comb begin
        re_c     = work[idx][DW-1:HW];
        im_c     = work[idx][HW-1:0];
        mag_c    = DW'($unsigned(DW'(re_c) * DW'(re_c) + DW'(im_c) * DW'(im_c)));
        better_c = (idx == '0) || (mag_c > best_mag);
    end

    // Frame buffers carry no reset; their contents are only read after a load
    always_ff @(posedge clk) begin
        for (int unsigned k = 0; k < NBINS; k++) begin
            if (load_new_c) begin
                work[k] <= fft_d[k];
            end else if (load_pend_work_c) begin
                work[k] <= pend[k];
            end
            if (cap_pend_c) begin
                pend[k] <= fft_d[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            idx       <= '0;
            pend_vld  <= 1'b0;
            best_mag  <= '0;
            best_idx  <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            ovf_q     <= 1'b0;
            freq_q    <= '0;
            max_mag_q <= '0;
        end else begin
            done_q <= 1'b0;
            if (drop_c) begin
                ovf_q <= 1'b1;
            end
            if (cap_pend_c) begin
                pend_vld <= 1'b1;
            end else if (load_pend_work_c) begin
                pend_vld <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (bus.fft_valid) begin
                        state    <= CALC;
                        busy_q   <= 1'b1;
                        idx      <= '0;
                        best_mag <= '0;
                        best_idx <= '0;
                    end
                end
                CALC: begin
                    if (better_c) begin
                        best_mag <= mag_c;
                        best_idx <= idx;
                    end
                    if (last_c) begin
                        done_q    <= 1'b1;
                        freq_q    <= better_c ? idx   : best_idx;
                        max_mag_q <= better_c ? mag_c : best_mag;
                        idx       <= '0;
                        if (!(pend_vld || bus.fft_valid)) begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
                        end
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.done    = done_q;
    assign bus.freq    = freq_q;
    assign bus.max_mag = max_mag_q;
    assign bus.busy    = busy_q;
    assign bus.ovf     = ovf_q;

endmodule

// File: tb/tb_freq_analysis.sv
// Self-checking bench for freq_analysis: directed frames plus randomized frame
// streams scored against a frame-level scheduling and peak-search model.
module tb_freq_analysis;
    logic clk;
    logic rst;
    logic [31:0] cur [16];
    int   edge_n;
    int   checks;
    int   errors;

    typedef struct {
        int          edge_no;
        logic [3:0]  f;
        logic [31:0] m;
    } exp_t;

    exp_t q[$];
    int   m_last_fin;
    logic m_ovf;
    logic [3:0]  last_f;
    logic [31:0] last_m;

    freq_analysis_if bus ();

    freq_analysis dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.fft_d0  = cur[0];
    assign bus.fft_d1  = cur[1];
    assign bus.fft_d2  = cur[2];
    assign bus.fft_d3  = cur[3];
    assign bus.fft_d4  = cur[4];
    assign bus.fft_d5  = cur[5];
    assign bus.fft_d6  = cur[6];
    assign bus.fft_d7  = cur[7];
    assign bus.fft_d8  = cur[8];
    assign bus.fft_d9  = cur[9];
    assign bus.fft_d10 = cur[10];
    assign bus.fft_d11 = cur[11];
    assign bus.fft_d12 = cur[12];
    assign bus.fft_d13 = cur[13];
    assign bus.fft_d14 = cur[14];
    assign bus.fft_d15 = cur[15];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Peak search straight from the definition: largest re^2+im^2, lowest index on ties
    function automatic void peak(output logic [3:0] f, output logic [31:0] m);
        longint best;
        longint re;
        longint im;
        longint mg;
        best = -1;
        f    = 4'd0;
        for (int k = 0; k < 16; k++) begin
            re = longint'($signed(cur[k][31:16]));
            im = longint'($signed(cur[k][15:0]));
            mg = re * re + im * im;
            if (mg > best) begin
                best = mg;
                f    = 4'(k);
            end
        end
        m = 32'(best);
    endfunction

    // Each frame needs 16 edges; at most one frame may wait behind the active one
    function automatic void model_strobe(input int t);
        exp_t e;
        int   fin;
        if (t >= m_last_fin) begin
            fin = t + 16;
        end else if (m_last_fin - 16 > t) begin
            m_ovf = 1'b1;
            return;
        end else begin
            fin = m_last_fin + 16;
        end
        m_last_fin = fin;
        peak(e.f, e.m);
        e.edge_no = fin;
        q.push_back(e);
    endfunction

    function automatic void model_reset();
        q.delete();
        m_last_fin = -1000;
        m_ovf      = 1'b0;
    endfunction

    always @(negedge clk) begin
        if (rst && bus.done) begin
            if (q.size() == 0) begin
                check("unexpected_done", 32'(edge_n), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("done_edge", 32'(edge_n), 32'(e.edge_no));
                check("freq", 32'(bus.freq), 32'(e.f));
                check("max_mag", bus.max_mag, e.m);
                check("ovf_at_done", 32'(bus.ovf), 32'(m_ovf));
                last_f = e.f;
                last_m = e.m;
            end
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic send();
        bus.fft_valid = 1'b1;
        model_strobe(edge_n + 1);
        @(negedge clk);
        bus.fft_valid = 1'b0;
    endtask

    task automatic clear_frame();
        for (int k = 0; k < 16; k++) cur[k] = 32'h0;
    endtask

    task automatic rand_frame();
        int v;
        int w;
        for (int k = 0; k < 16; k++) begin
            case ($urandom_range(0, 3))
                0: cur[k] = $urandom;
                1: begin
                    v = int'($urandom_range(0, 8)) - 4;
                    w = int'($urandom_range(0, 8)) - 4;
                    cur[k] = {16'(v), 16'(w)};
                end
                2: cur[k] = 32'h0;
                default: begin
                    case ($urandom_range(0, 3))
                        0: cur[k] = 32'h8000_8000;
                        1: cur[k] = 32'h8000_0000;
                        2: cur[k] = 32'h0000_8000;
                        default: cur[k] = 32'h7FFF_7FFF;
                    endcase
                end
            endcase
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 400 && q.size() > 0; i++) @(negedge clk);
        check("drain_timeout", 32'(q.size()), 32'd0);
        idle(2);
        check("idle_busy", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        edge_n        = 0;
        last_f        = 4'd0;
        last_m        = 32'd0;
        rst           = 1'b0;
        bus.fft_valid = 1'b0;
        clear_frame();
        model_reset();

        // Reset state
        idle(3);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_freq", 32'(bus.freq), 32'd0);
        check("rst_max_mag", bus.max_mag, 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_ovf", 32'(bus.ovf), 32'd0);
        rst = 1'b1;
        idle(20);

        // Single bin 5
        clear_frame();
        cur[5] = 32'h0100_0000;
        send();
        check("busy_after_capture", 32'(bus.busy), 32'd1);
        wait_drain();
        check("bin5_freq", 32'(bus.freq), 32'd5);
        check("bin5_mag", bus.max_mag, 32'h0001_0000);

        // Negative real vs. mixed bin
        clear_frame();
        cur[3] = 32'hFF00_0000;
        cur[9] = 32'h00C0_00C0;
        send();
        wait_drain();
        check("sign_freq", 32'(bus.freq), 32'd9);
        check("sign_mag", bus.max_mag, 32'h0001_2000);

        // Tie keeps lowest index
        clear_frame();
        cur[2] = 32'h0010_0010;
        cur[7] = 32'h0010_0010;
        send();
        wait_drain();
        check("tie_freq", 32'(bus.freq), 32'd2);
        check("tie_mag", bus.max_mag, 32'h0000_0200);

        // Extreme negative values
        clear_frame();
        cur[14] = 32'h8000_8000;
        send();
        wait_drain();
        check("ext_freq", 32'(bus.freq), 32'd14);
        check("ext_mag", bus.max_mag, 32'h8000_0000);
        idle(5);
        check("hold_freq", 32'(bus.freq), 32'd14);
        check("hold_mag", bus.max_mag, 32'h8000_0000);

        // A then B exactly 16 edges apart
        clear_frame();
        cur[4] = 32'h0040_0000;
        send();
        idle(15);
        clear_frame();
        cur[11] = 32'h0000_0050;
        send();
        wait_drain();
        check("ab_last_freq", 32'(bus.freq), 32'd11);
        check("ab_ovf", 32'(bus.ovf), 32'd0);

        // Pending plus new frame on the idx=15 edge
        rand_frame();
        send();
        idle(2);
        rand_frame();
        send();
        idle(12);
        rand_frame();
        send();
        check("pend15_ovf", 32'(bus.ovf), 32'd0);
        wait_drain();

        // Randomized frame stream with gaps that sometimes cause drops
        for (int n = 0; n < 40; n++) begin
            rand_frame();
            send();
            idle(int'($urandom_range(0, 20)));
        end
        wait_drain();
        check("rand_ovf", 32'(bus.ovf), 32'(m_ovf));
        check("rand_hold_freq", 32'(bus.freq), 32'(last_f));
        check("rand_hold_mag", bus.max_mag, last_m);

        // Three consecutive strobes: third is dropped
        rand_frame();
        send();
        rand_frame();
        send();
        rand_frame();
        send();
        check("burst_ovf", 32'(bus.ovf), 32'd1);
        wait_drain();

        // Reset at idx=8 aborts the frame and clears ovf
        rand_frame();
        send();
        idle(8);
        check("pre_rst_ovf", 32'(bus.ovf), 32'd1);
        rst = 1'b0;
        model_reset();
        #1;
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_ovf", 32'(bus.ovf), 32'd0);
        check("abort_freq", 32'(bus.freq), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        idle(30);

        // First frame after reset is processed normally
        clear_frame();
        cur[6] = 32'h0003_FFFC;
        send();
        wait_drain();
        check("post_rst_freq", 32'(bus.freq), 32'd6);
        check("post_rst_mag", bus.max_mag, 32'h0000_0019);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
